// File: rtl/id_stage.sv
// RV32I decode / operand-fetch stage with a registered ID/EX output slot.
// Optional feature macro: ID_SCOREBOARD_EN adds per-register in-flight counters and RAW stalls.
module id_stage #(
   parameter int XLEN  = 32,
   parameter int CNT_W = 2
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [31:0]     in_pc,
   input  logic [31:0]     in_inst,
   output logic            read_enable1,
   output logic [4:0]      read_addr1,
   input  logic [XLEN-1:0] read_data1,
   output logic            read_enable2,
   output logic [4:0]      read_addr2,
   input  logic [XLEN-1:0] read_data2,
   input  logic            wb_enable,
   input  logic [4:0]      wb_addr,
   input  logic            jump_or_not,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [31:0]     out_pc,
   output logic [XLEN-1:0] out_rs1_data,
   output logic [XLEN-1:0] out_rs2_data,
   output logic [31:0]     out_imm,
   output logic [4:0]      out_rd,
   output logic [6:0]      out_opcode,
   output logic [2:0]      out_funct3,
   output logic            out_funct7b5,
   output logic            out_wb_en,
   output logic            out_illegal
);

   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_OPIMM  = 7'b0010011;
   localparam logic [6:0] OP_OP     = 7'b0110011;

   logic [6:0]      w_opcode;
   logic [4:0]      w_rd;
   logic [4:0]      w_rs1;
   logic [4:0]      w_rs2;
   logic [31:0]     w_imm;
   logic            w_use1;
   logic            w_use2;
   logic            w_writes;
   logic            w_illegal;
   logic            w_wbEn;
   logic            w_stall;
   logic            w_accept;

   logic            r_outValid;
   logic [31:0]     r_outPc;
   logic [XLEN-1:0] r_outRs1;
   logic [XLEN-1:0] r_outRs2;
   logic [31:0]     r_outImm;
   logic [4:0]      r_outRd;
   logic [6:0]      r_outOpcode;
   logic [2:0]      r_outFunct3;
   logic            r_outFunct7b5;
   logic            r_outWbEn;
   logic            r_outIllegal;

   assign w_opcode = in_inst[6:0];
   assign w_rd     = in_inst[11:7];
   assign w_rs1    = in_inst[19:15];
   assign w_rs2    = in_inst[24:20];

   // Opcode class decides the immediate format, which source ports are used and whether rd is written.
   // Illegal instructions read nothing, so they can never stall.
   always_comb begin
      w_imm     = 32'h0;
      w_use1    = 1'b0;
      w_use2    = 1'b0;
      w_writes  = 1'b0;
      w_illegal = 1'b0;
      case (w_opcode)
         OP_LUI, OP_AUIPC: begin
            w_imm    = {in_inst[31:12], 12'h000};
            w_writes = 1'b1;
         end
         OP_JAL: begin
            w_imm    = {{12{in_inst[31]}}, in_inst[19:12], in_inst[20], in_inst[30:21], 1'b0};
            w_writes = 1'b1;
         end
         OP_JALR, OP_LOAD, OP_OPIMM: begin
            w_imm    = {{21{in_inst[31]}}, in_inst[30:20]};
            w_use1   = 1'b1;
            w_writes = 1'b1;
         end
         OP_BRANCH: begin
            w_imm  = {{20{in_inst[31]}}, in_inst[7], in_inst[30:25], in_inst[11:8], 1'b0};
            w_use1 = 1'b1;
            w_use2 = 1'b1;
         end
         OP_STORE: begin
            w_imm  = {{21{in_inst[31]}}, in_inst[30:25], in_inst[11:7]};
            w_use1 = 1'b1;
            w_use2 = 1'b1;
         end
         OP_OP: begin
            w_use1   = 1'b1;
            w_use2   = 1'b1;
            w_writes = 1'b1;
         end
         default: w_illegal = 1'b1;
      endcase
   end

   assign w_wbEn       = w_writes && (w_rd != 5'd0);
   assign read_enable1 = in_valid && w_use1;
   assign read_enable2 = in_valid && w_use2;
   assign read_addr1   = in_valid ? w_rs1 : 5'd0;
   assign read_addr2   = in_valid ? w_rs2 : 5'd0;

   assign in_ready = rst_n && !jump_or_not && !w_stall && (!r_outValid || out_ready);
   assign w_accept = in_valid && in_ready;

`ifdef ID_SCOREBOARD_EN
   localparam logic [CNT_W-1:0] C_MAX = '1;
   localparam logic [CNT_W-1:0] C_ONE = CNT_W'(1);

   logic [CNT_W-1:0] r_cnt     [32];
   logic [CNT_W-1:0] w_cntNext [32];
   logic             w_haz1;
   logic             w_haz2;
   logic             w_sat;
   logic             w_squash;

   // A pending source with exactly one writer that is writing back right now is served by the bypass.
   always_comb begin
      w_haz1  = w_use1 && (w_rs1 != 5'd0) && (r_cnt[w_rs1] != '0)
                && !((r_cnt[w_rs1] == C_ONE) && wb_enable && (wb_addr == w_rs1));
      w_haz2  = w_use2 && (w_rs2 != 5'd0) && (r_cnt[w_rs2] != '0)
                && !((r_cnt[w_rs2] == C_ONE) && wb_enable && (wb_addr == w_rs2));
      w_sat   = w_wbEn && (r_cnt[w_rd] == C_MAX);
      w_stall = w_haz1 || w_haz2 || w_sat;
   end

   assign w_squash = jump_or_not && r_outValid && r_outWbEn;

   // Issue increments, writeback and squash each decrement; decrements floor at zero and x0 stays untracked.
   always_comb begin
      for (int i = 0; i < 32; i++) begin
         w_cntNext[i] = r_cnt[i];
         if (i != 0) begin
            if (w_accept && w_wbEn && (w_rd == 5'(i)))
               w_cntNext[i] = w_cntNext[i] + C_ONE;
            if (wb_enable && (wb_addr == 5'(i)) && (w_cntNext[i] != '0))
               w_cntNext[i] = w_cntNext[i] - C_ONE;
            if (w_squash && (r_outRd == 5'(i)) && (w_cntNext[i] != '0))
               w_cntNext[i] = w_cntNext[i] - C_ONE;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 32; i++) r_cnt[i] <= '0;
      end else begin
         for (int i = 0; i < 32; i++) r_cnt[i] <= w_cntNext[i];
      end
   end
`else
   logic w_unused;

   assign w_stall  = 1'b0;
   assign w_unused = ^{wb_enable, wb_addr, (CNT_W != 0)};
`endif

   // ID/EX slot: a flush kills it, an accept loads it, otherwise it drains when EX takes it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_outValid    <= 1'b0;
         r_outPc       <= '0;
         r_outRs1      <= '0;
         r_outRs2      <= '0;
         r_outImm      <= '0;
         r_outRd       <= '0;
         r_outOpcode   <= '0;
         r_outFunct3   <= '0;
         r_outFunct7b5 <= 1'b0;
         r_outWbEn     <= 1'b0;
         r_outIllegal  <= 1'b0;
      end else if (jump_or_not) begin
         r_outValid <= 1'b0;
      end else if (w_accept) begin
         r_outValid    <= 1'b1;
         r_outPc       <= in_pc;
         r_outRs1      <= read_data1;
         r_outRs2      <= read_data2;
         r_outImm      <= w_imm;
         r_outRd       <= w_rd;
         r_outOpcode   <= w_opcode;
         r_outFunct3   <= in_inst[14:12];
         r_outFunct7b5 <= in_inst[30];
         r_outWbEn     <= w_wbEn;
         r_outIllegal  <= w_illegal;
      end else if (out_ready) begin
         r_outValid <= 1'b0;
      end
   end

   assign out_valid    = r_outValid;
   assign out_pc       = r_outPc;
   assign out_rs1_data = r_outRs1;
   assign out_rs2_data = r_outRs2;
   assign out_imm      = r_outImm;
   assign out_rd       = r_outRd;
   assign out_opcode   = r_outOpcode;
   assign out_funct3   = r_outFunct3;
   assign out_funct7b5 = r_outFunct7b5;
   assign out_wb_en    = r_outWbEn;
   assign out_illegal  = r_outIllegal;

endmodule

// File: doc/id_stage.md
# id_stage

Instruction decode and operand-fetch stage of the RV32I pipeline. It sits between the IF/ID latch and the EX stage. It decodes fields and immediates, drives both read ports of the register file, and captures the returned operands into a registered ID/EX output. It stalls on read-after-write hazards using per-register in-flight counters and squashes its output on a taken jump.

## Interface
- XLEN, 32, datapath width
- CNT_W, 2, width of each per-register in-flight counter (saturates at 2^CNT_W−1)

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  instruction available from IF/ID
- in_ready  out  1  stage accepts instruction this cycle
- in_pc  in  32  instruction PC
- in_inst  in  32  instruction word
- read_enable1 / read_addr1  out  1 / 5  register file port 1 request (rs1)
- read_data1  in  32  port 1 data, combinational, same-cycle writeback bypass
- read_enable2 / read_addr2 / read_data2  same for rs2
- wb_enable  in  1  register file write enable (snooped)
- wb_addr  in  5  register file write address (snooped)
- jump_or_not  in  1  taken jump or branch resolved in EX; flush
- out_valid  out  1  ID/EX entry valid
- out_ready  in  1  EX accepts entry
- out_pc, out_rs1_data, out_rs2_data, out_imm  out  32 each
- out_rd  out  5; out_opcode  out  7; out_funct3  out  3; out_funct7b5  out  1
- out_wb_en  out  1  instruction writes rd (rd≠0)
- out_illegal  out  1  unsupported opcode

## Operation
- Opcode classes and immediate selection:
  - LUI 0110111: U-type
  - AUIPC 0010111: U-type
  - JAL 1101111: J-type
  - JALR 1100111: I-type
  - BRANCH 1100011: B-type
  - LOAD 0000011: I-type
  - STORE 0100011: S-type
  - OP-IMM 0010011: I-type
  - OP 0110011: imm = 0
  - Any other opcode: out_illegal=1, out_wb_en=0, imm=0
- Immediates are sign-extended to 32 bits. B-type and J-type immediates have bit 0 = 0.
- read_enable1 is asserted for every class except LUI, AUIPC and JAL. read_enable2 is asserted for BRANCH, STORE and OP. Addresses are driven from in_inst[19:15] and [24:20] whenever in_valid=1.
- out_wb_en = (rd≠0) AND class ∉ {BRANCH, STORE, illegal}.
- Scoreboard: one CNT_W counter per register x1–x31. x0 is never tracked.
  - Increment on transfer out of ID (in_valid && in_ready) with wb_en.
  - Decrement on wb_enable && wb_addr≠0.
  - Increment and decrement of the same register in one cycle leave the counter unchanged.
- Hazard on a used source rs (rs≠0): stall when cnt[rs]=0 is false, unless cnt[rs]=1 AND wb_enable AND wb_addr=rs. In that case the register file bypass supplies the correct data.
- Additional stall if the instruction would increment a counter already at its maximum.
- Flush (jump_or_not=1):
  - in_ready=0; no instruction is accepted.
  - If out_valid=1 and out_wb_en=1, cnt[out_rd] is decremented, because that instruction is squashed and will never write back.
  - out_valid is cleared next edge.
  - A same-cycle writeback decrement on the same register is applied as well (net −2).

## Timing
- in_ready = in_valid-independent: !jump_or_not && !stall && (!out_valid || out_ready).
- Latency is one cycle. Operands and decoded fields are registered on the accepting edge.
- out_valid=1 holds with all out_* fields stable until out_ready=1.
- Back-to-back issue is one per cycle when no hazard exists.
- Reset (async, rst_n=0): out_valid=0, all out_* = 0, all counters = 0. in_ready is low while in reset.
- Reset asserted mid-stall discards the held instruction. No counter leak survives, because all counters are cleared.
- Counter underflow (decrement at 0) is a bench assertion failure. RTL holds the counter at 0.

## Configuration
- ID_SCOREBOARD_EN
  - Defined: scoreboard and hazard stalls as above.
  - Undefined: counters and stall logic are removed. in_ready = !jump_or_not && (!out_valid || out_ready), and EX is responsible for forwarding. Flush still clears out_valid.

## Test plan
- Reset with in_valid=1 → out_valid=0, outputs 0. First edge after rst_n=1 issues the instruction, and out_valid=1 one cycle later.
- addi x1,x0,5 then add x2,x1,x1 back-to-back → second instruction stalls (in_ready=0) until wb_enable with wb_addr=1. It issues in that same cycle, with out_rs1_data=out_rs2_data=write data.
- sw x3,8(x4) → out_imm=0x00000008, out_wb_en=0, read_enable2=1, no counter change.
- Inst 0xFFFFFFFF → out_illegal=1, out_wb_en=0, no stall.
- lw x5 in ID/EX, then jump_or_not=1 → out_valid=0 next cycle, cnt[5]=0, and a following read of x5 does not stall.
- Three writes to x7 in flight (cnt=3, CNT_W=2) → a fourth writer of x7 stalls until a wb_addr=7 writeback occurs.
